// File: rtl/jtag_user_dr_if.sv
// SoC-side bundle of the JTAG USER data register: the parallel capture word
// going into the scan chain and the valid/ready delivery of updated words.
interface jtag_user_dr_if #(
  parameter int DR_WIDTH = 32
) ();
  logic [DR_WIDTH-1:0] capture_data;
  logic [DR_WIDTH-1:0] update_data;
  logic                update_valid;
  logic                update_ready;
  logic                overrun;

  // The data register drives delivered words and samples the capture word.
  modport master (
    input  capture_data,
    input  update_ready,
    output update_data,
    output update_valid,
    output overrun
  );

  // The SoC supplies the capture word and accepts delivered words.
  modport slave (
    output capture_data,
    output update_ready,
    input  update_data,
    input  update_valid,
    input  overrun
  );
endinterface

// File: rtl/jtag_user_dr.sv
// JTAG USER data register, responder side. Scan-side signals are
// oversampled in the clk_i domain. TCK edges are detected from the
// synchronized copy. Captured words shift out on TDO while new words shift
// in from TDI. Updated words go to the SoC through a valid/ready handshake.
module jtag_user_dr #(
  parameter int DR_WIDTH    = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           jtag_tck_i,
  input  logic           jtag_tdi_i,
  input  logic           jtag_sel_i,
  input  logic           jtag_capture_i,
  input  logic           jtag_shift_i,
  input  logic           jtag_update_i,
  input  logic           jtag_reset_i,
  output logic           jtag_tdo_o,
  jtag_user_dr_if.master soc
);

  // Bit positions of the scan inputs inside the synchronizer word.
  localparam int B_TCK = 0;
  localparam int B_TDI = 1;
  localparam int B_SEL = 2;
  localparam int B_CAP = 3;
  localparam int B_SHF = 4;
  localparam int B_UPD = 5;
  localparam int B_RST = 6;
  localparam int N_IN  = 7;

  logic [N_IN-1:0]     raw_in;
  logic [N_IN-1:0]     sync_q [SYNC_STAGES];
  logic [N_IN-1:0]     s_in;
  logic                tck_prev;
  logic                rise;
  logic                fall;
  logic                deliver;
  logic [DR_WIDTH-1:0] sr;
  logic [DR_WIDTH-1:0] update_data_q;
  logic                update_valid_q;
  logic                overrun_q;

  assign raw_in = {jtag_reset_i, jtag_update_i, jtag_shift_i, jtag_capture_i,
                   jtag_sel_i, jtag_tdi_i, jtag_tck_i};

  // All scan inputs move through one shared chain so they stay aligned.
  // NOTE: every stage is reset, not just the last one; otherwise stale
  // ones left in the array could fake a TCK edge right after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make each stage take the previous
      // stage's old value, which is what makes this a shift chain.
      sync_q[0] <= raw_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s_in = sync_q[SYNC_STAGES-1];

  // Keep the previous synchronized TCK level for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tck_prev <= 1'b0;
    else       tck_prev <= s_in[B_TCK];
  end

  assign rise = s_in[B_TCK] & ~tck_prev;
  assign fall = ~s_in[B_TCK] & tck_prev;

  // Update-DR is the lowest-priority action in a selected rise cycle.
  assign deliver = rise & s_in[B_SEL] & ~s_in[B_RST] & ~s_in[B_CAP] &
                   ~s_in[B_SHF] & s_in[B_UPD];

  // Scan chain: Test-Logic-Reset, then capture, then shift (LSB out first).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr <= '0;
    end else if (rise && s_in[B_SEL]) begin
      if (s_in[B_RST])      sr <= '0;
      else if (s_in[B_CAP]) sr <= soc.capture_data;
      else if (s_in[B_SHF]) sr <= {s_in[B_TDI], sr[DR_WIDTH-1:1]};
    end
  end

  // Delivery and handshake. A delivery that coincides with an accept
  // replaces the word cleanly. Otherwise a pending word is overwritten
  // and the loss is flagged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      update_data_q  <= '0;
      update_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      if (rise && s_in[B_SEL] && s_in[B_RST]) overrun_q <= 1'b0;
      if (deliver) begin
        update_data_q  <= sr;
        update_valid_q <= 1'b1;
        if (update_valid_q && !soc.update_ready) overrun_q <= 1'b1;
      end else if (update_valid_q && soc.update_ready) begin
        update_valid_q <= 1'b0;
      end
    end
  end

  // Launch TDO on the synchronized falling edge. It is then stable when
  // the TAP samples at its next rising edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     jtag_tdo_o <= 1'b0;
    else if (fall) jtag_tdo_o <= sr[0];
  end

  assign soc.update_data  = update_data_q;
  assign soc.update_valid = update_valid_q;
  assign soc.overrun      = overrun_q;

endmodule

// File: tb/tb_jtag_user_dr.sv
// Directed bench for jtag_user_dr. Expected TDO bits and delivered words
// are queued when a scan is driven. They are popped and compared when the
// DUT presents them.
module tb_jtag_user_dr;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tck = 1'b0, tdi = 1'b0, sel = 1'b0, cap = 1'b0, shf = 1'b0;
  logic upd = 1'b0, trst = 1'b0;
  logic tdo;

  int total = 0;
  int bad   = 0;

  logic          tdo_q [$];
  logic [W-1:0]  upd_q [$];
  logic          valid_hist [4];

  jtag_user_dr_if #(.DR_WIDTH(W)) soc_if ();

  jtag_user_dr #(.DR_WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .jtag_tck_i     (tck),
    .jtag_tdi_i     (tdi),
    .jtag_sel_i     (sel),
    .jtag_capture_i (cap),
    .jtag_shift_i   (shf),
    .jtag_update_i  (upd),
    .jtag_reset_i   (trst),
    .jtag_tdo_o     (tdo),
    .soc            (soc_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tdo"}, W'(tdo), '0);
    check({tag, "_data"}, soc_if.update_data, '0);
    check({tag, "_valid"}, W'(soc_if.update_valid), '0);
    check({tag, "_ovr"}, W'(soc_if.overrun), '0);
  endtask

  // One TCK period: controls set at the start of the low phase, four clk
  // cycles low, four high. TDO is sampled just before TCK rises, like the
  // TAP does. With rdy_at_rise set, update_ready pulses in the rise cycle.
  task automatic tck_cycle(input logic c, s, u, r, d, rdy_at_rise);
    cap = c; shf = s; upd = u; trst = r; tdi = d;
    repeat (4) begin @(posedge clk); #1; end
    if (s && sel && tdo_q.size() > 0) check("tdo_bit", W'(tdo), W'(tdo_q.pop_front()));
    tck = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      valid_hist[k] = soc_if.update_valid;
      if (rdy_at_rise && k == 1) soc_if.update_ready = 1'b1;
      if (rdy_at_rise && k == 2) soc_if.update_ready = 1'b0;
    end
    tck = 1'b0;
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) tdo_q.push_back(w[i]);
  endtask

  task automatic shift_word(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) tck_cycle(1'b0, 1'b1, 1'b0, 1'b0, w[i], 1'b0);
  endtask

  task automatic do_update();
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // Accept the pending word with a one-cycle ready pulse.
  task automatic accept(input string tag);
    logic [W-1:0] exp;
    exp = (upd_q.size() > 0) ? upd_q.pop_front() : 'x;
    check({tag, "_valid"}, W'(soc_if.update_valid), W'(1));
    check({tag, "_data"}, soc_if.update_data, exp);
    soc_if.update_ready = 1'b1;
    @(posedge clk); #1;
    soc_if.update_ready = 1'b0;
    check({tag, "_valid_fall"}, W'(soc_if.update_valid), '0);
  endtask

  initial begin
    logic [W-1:0] front;
    soc_if.capture_data = '0;
    soc_if.update_ready = 1'b0;

    // Reset state.
    repeat (3) begin @(posedge clk); #1; end
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Capture and shift-out, LSB first.
    sel = 1'b1;
    soc_if.capture_data = 32'hA5C3_0F81;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push_word(32'hA5C3_0F81);
    shift_word(32'h0);

    // Shift-in with the emptied chain visible on TDO, then update.
    push_word(32'h0);
    shift_word(32'h1234_5678);
    do_update();
    check("upd_valid_edge2", W'(valid_hist[1]), '0);
    check("upd_valid_edge3", W'(valid_hist[2]), W'(1));
    upd_q.push_back(32'h1234_5678);
    check("upd_ovr", W'(soc_if.overrun), '0);
    accept("upd");

    // Overrun: two deliveries with no accept in between.
    push_word(32'h1234_5678);
    shift_word(32'h1111_1111);
    do_update();
    upd_q.push_back(32'h1111_1111);
    check("ovr_pre", W'(soc_if.overrun), '0);
    push_word(32'h1111_1111);
    shift_word(32'h2222_2222);
    do_update();
    void'(upd_q.pop_front());
    upd_q.push_back(32'h2222_2222);
    check("ovr_set", W'(soc_if.overrun), W'(1));
    check("ovr_data", soc_if.update_data, 32'h2222_2222);
    tck_cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("ovr_tlr_clear", W'(soc_if.overrun), '0);
    accept("ovr_acc");

    // Accept coinciding with the next update rise.
    push_word(32'h0);
    shift_word(32'h3333_3333);
    do_update();
    upd_q.push_back(32'h3333_3333);
    push_word(32'h3333_3333);
    shift_word(32'h4444_4444);
    front = (upd_q.size() > 0) ? upd_q.pop_front() : 'x;
    check("sim_old_data", soc_if.update_data, front);
    tck_cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    upd_q.push_back(32'h4444_4444);
    check("sim_valid", W'(soc_if.update_valid), W'(1));
    check("sim_ovr", W'(soc_if.overrun), '0);
    accept("sim_acc");

    // Deselected: nothing changes.
    sel = 1'b0;
    soc_if.capture_data = 32'hDEAD_BEEF;
    tck_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    shift_word(32'hFFFF_FFFF);
    do_update();
    check("desel_valid", W'(soc_if.update_valid), '0);
    check("desel_tdo", W'(tdo), '0);
    sel = 1'b1;
    push_word(32'h4444_4444);
    shift_word(32'h0);

    // Build up state (pending word, overrun, TDO=1), then reset mid-shift.
    push_word(32'h0);
    shift_word(32'hFFFF_FFFF);
    do_update();
    push_word(32'hFFFF_FFFF);
    shift_word(32'hFFFF_FFFF);
    do_update();
    check("pre_rst_ovr", W'(soc_if.overrun), W'(1));
    check("pre_rst_valid", W'(soc_if.update_valid), W'(1));
    check("pre_rst_tdo", W'(tdo), W'(1));
    check("tdo_q_drained", W'(tdo_q.size()), '0);
    shf = 1'b1; tdi = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    tck = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_all_zero("async_rst");
    tck = 1'b0; shf = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    check_all_zero("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
